// File: rtl/mnist_layer_sequencer_pkg.sv
// Shared constants and state encoding for the MNIST MAC sequencer.
// Weight ROM holds the hidden layer first, then the output layer.
package mnist_acc_pkg;

    localparam int N_IN       = 64;
    localparam int N_HID      = 16;
    localparam int N_OUT      = 10;
    localparam int ACC_W      = 20;
    localparam int W_ADDR_W   = 11;
    localparam int HID_W_BASE = 0;
    localparam int OUT_W_BASE = 1024;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_MAC,
        S_DRAIN,
        S_WB,
        S_DONE
    } state_e;

endpackage

// File: rtl/mnist_layer_sequencer_if.sv
// Sequencer <-> MAC/ROM/activation-buffer datapath bundle.
interface mnist_layer_sequencer_if;
    import mnist_acc_pkg::*;

    logic                       stall;
    logic signed [ACC_W-1:0]    acc_in;
    logic                       layer_sel;
    logic [5:0]                 in_addr;
    logic [W_ADDR_W-1:0]        w_addr;
    logic                       mac_clr;
    logic                       mac_en;
    logic                       act_wr;
    logic [3:0]                 act_addr;

    modport master (
        input  stall, acc_in,
        output layer_sel, in_addr, w_addr,
        output mac_clr, mac_en, act_wr, act_addr
    );

    modport slave (
        output stall, acc_in,
        input  layer_sel, in_addr, w_addr,
        input  mac_clr, mac_en, act_wr, act_addr
    );

endinterface

// File: rtl/mnist_layer_sequencer_argmax.sv
// Running argmax of output scores; index 0 always loads, later
// indices replace only on a strictly greater signed score.
module mnist_argmax
    import mnist_acc_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    upd,
    input  logic [3:0]              idx_in,
    input  logic signed [ACC_W-1:0] val_in,
    output logic [3:0]              best_idx
);

    logic signed [ACC_W-1:0] best_q, best_d;
    logic [3:0]              idx_q, idx_d;

    always_comb begin
        best_d = best_q;
        idx_d  = idx_q;
        if (clr) begin
            best_d = '0;
            idx_d  = '0;
        end else if (upd && (idx_in == 4'd0 || val_in > best_q)) begin
            best_d = val_in;
            idx_d  = idx_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            best_q <= '0;
            idx_q  <= '0;
        end else begin
            best_q <= best_d;
            idx_q  <= idx_d;
        end
    end

    assign best_idx = idx_q;

endmodule

// File: rtl/mnist_layer_sequencer.sv
// Two-layer FC control FSM driving the shared MAC datapath.
// One neuron = CLR + fan MAC issues + DRAIN + WB.
module mnist_layer_sequencer
    import mnist_acc_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [3:0]               class_out,
    mnist_layer_sequencer_if.master  dp
);

    state_e              state_q, state_d;
    logic [3:0]          j_q, j_d;
    logic [5:0]          k_q, k_d;
    logic                layer_q, layer_d;
    logic [W_ADDR_W-1:0] w_addr_q, w_addr_d;
    logic                pend_q, pend_d;
    logic [3:0]          class_q, class_d;

    logic                stall_eff;
    logic [5:0]          fan_last;
    logic [3:0]          j_last;
    logic                am_clr;
    logic                am_upd;
    logic [3:0]          best_idx;

    always_comb begin
        state_d  = state_q;
        j_d      = j_q;
        k_d      = k_q;
        layer_d  = layer_q;
        w_addr_d = w_addr_q;
        class_d  = class_q;
        am_clr   = 1'b0;
        am_upd   = 1'b0;
        dp.mac_clr = 1'b0;
        dp.act_wr  = 1'b0;

        busy = (state_q == S_CLR) || (state_q == S_MAC) ||
               (state_q == S_DRAIN) || (state_q == S_WB);
        stall_eff = dp.stall && busy;
        fan_last  = layer_q ? 6'(N_HID - 1) : 6'(N_IN - 1);
        j_last    = layer_q ? 4'(N_OUT - 1) : 4'(N_HID - 1);

        // Pending read: set by an issue, held across stalls.
        pend_d = stall_eff ? pend_q : (state_q == S_MAC);

        unique case (state_q)
            S_IDLE: begin
                j_d      = '0;
                k_d      = '0;
                layer_d  = 1'b0;
                w_addr_d = W_ADDR_W'(HID_W_BASE);
                if (start) begin
                    am_clr  = 1'b1;
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                if (!stall_eff) begin
                    dp.mac_clr = 1'b1;
                    k_d        = '0;
                    state_d    = S_MAC;
                end
            end
            S_MAC: begin
                if (!stall_eff) begin
                    w_addr_d = w_addr_q + 1'b1;
                    k_d      = k_q + 1'b1;
                    if (k_q == fan_last)
                        state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!stall_eff)
                    state_d = S_WB;
            end
            S_WB: begin
                if (!stall_eff) begin
                    dp.act_wr = !layer_q;
                    am_upd    = layer_q;
                    if (j_q != j_last) begin
                        j_d     = j_q + 1'b1;
                        state_d = S_CLR;
                    end else if (!layer_q) begin
                        layer_d  = 1'b1;
                        j_d      = '0;
                        w_addr_d = W_ADDR_W'(OUT_W_BASE);
                        state_d  = S_CLR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                class_d  = best_idx;
                j_d      = '0;
                k_d      = '0;
                layer_d  = 1'b0;
                w_addr_d = W_ADDR_W'(HID_W_BASE);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            j_q      <= '0;
            k_q      <= '0;
            layer_q  <= 1'b0;
            w_addr_q <= '0;
            pend_q   <= 1'b0;
            class_q  <= '0;
        end else begin
            state_q  <= state_d;
            j_q      <= j_d;
            k_q      <= k_d;
            layer_q  <= layer_d;
            w_addr_q <= w_addr_d;
            pend_q   <= pend_d;
            class_q  <= class_d;
        end
    end

    mnist_argmax u_argmax (
        .clk      (clk),
        .rst      (rst),
        .clr      (am_clr),
        .upd      (am_upd),
        .idx_in   (j_q),
        .val_in   (dp.acc_in),
        .best_idx (best_idx)
    );

    assign done         = (state_q == S_DONE);
    assign class_out    = done ? best_idx : class_q;
    assign dp.mac_en    = pend_q && !stall_eff;
    assign dp.layer_sel = layer_q;
    assign dp.in_addr   = k_q;
    assign dp.w_addr    = w_addr_q;
    assign dp.act_addr  = j_q;

endmodule
